// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
// Holds the fixed state encoding and the bit-counter width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // The bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  function automatic int unsigned cntWidth(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/dff_en_reg.sv
// Enable-gated D register with asynchronous active-low clear.
// Every piece of state in the multiplier is built from this cell.
module dff_en_reg #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier with a start/busy/done handshake.
// The controller supplies only enables and next-value muxing to dff_en_reg storage.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P
);

  import seq_mult_pkg::*;

  localparam int PW = 2 * WIDTH;
  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_p;

  state_t           w_state;
  logic [1:0]       w_state_d;
  logic             w_op_load;
  logic             w_step;
  logic             w_p_en;
  logic             w_iter_en;
  logic [PW-1:0]    w_partial;
  logic [PW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_mplier_d;
  logic [PW-1:0]    w_acc_d;
  logic [CW-1:0]    w_cnt_d;

  assign w_state = state_t'(r_state);

  always_comb begin
    w_state_d = r_state;
    w_op_load = 1'b0;
    w_step    = 1'b0;
    w_p_en    = 1'b0;
    case (w_state)
      ST_IDLE: begin
        if (START) begin
          w_op_load = 1'b1;
          w_state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_p_en    = 1'b1;
          w_state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        // A START seen while finishing starts the next multiply with no idle gap.
        if (START) begin
          w_op_load = 1'b1;
          w_state_d = ST_RUN;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_partial  = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    w_acc_next = r_acc + w_partial;
    w_mplier_d = w_op_load ? B  : (r_mplier >> 1);
    w_acc_d    = w_op_load ? '0 : w_acc_next;
    w_cnt_d    = w_op_load ? '0 : (r_cnt + CW'(1));
    w_iter_en  = w_op_load | w_step;
  end

  dff_en_reg #(.W(2)) u_state_reg (
    .CLK(CLK), .RST_N(RST_N), .EN(1'b1), .D(w_state_d), .Q(r_state)
  );

  dff_en_reg #(.W(WIDTH)) u_mcand_reg (
    .CLK(CLK), .RST_N(RST_N), .EN(w_op_load), .D(A), .Q(r_mcand)
  );

  dff_en_reg #(.W(WIDTH)) u_mplier_reg (
    .CLK(CLK), .RST_N(RST_N), .EN(w_iter_en), .D(w_mplier_d), .Q(r_mplier)
  );

  dff_en_reg #(.W(PW)) u_acc_reg (
    .CLK(CLK), .RST_N(RST_N), .EN(w_iter_en), .D(w_acc_d), .Q(r_acc)
  );

  dff_en_reg #(.W(CW)) u_cnt_reg (
    .CLK(CLK), .RST_N(RST_N), .EN(w_iter_en), .D(w_cnt_d), .Q(r_cnt)
  );

  // The product captures the final sum including the last iteration's partial.
  dff_en_reg #(.W(PW)) u_p_reg (
    .CLK(CLK), .RST_N(RST_N), .EN(w_p_en), .D(w_acc_next), .Q(r_p)
  );

  assign BUSY = (w_state == ST_RUN);
  assign DONE = (w_state == ST_FIN);
  assign P    = r_p;

endmodule
